// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detect, 3-point majority vote per bit,
// deserializer strobes, parity/stop checking and good-frame flag.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  deser_en,
    output logic                  sampled_bit,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_cap0;
    logic                  r_cap1;
    logic                  r_par_acc;
    logic                  r_deser_en;
    logic                  r_sampled_bit;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic [PRESCALE_W-1:0] w_mid;
    logic [PRESCALE_W-1:0] w_mid_m1;
    logic [PRESCALE_W-1:0] w_mid_p1;
    logic [PRESCALE_W-1:0] w_last_edge;
    logic                  w_bit_end;
    logic                  w_sample_pt;
    logic                  w_vote;
    logic                  w_last_bit;

    assign w_mid       = r_presc >> 1;
    assign w_mid_m1    = w_mid - PRESCALE_W'(1);
    assign w_mid_p1    = w_mid + PRESCALE_W'(1);
    assign w_last_edge = r_presc - PRESCALE_W'(1);
    assign w_bit_end   = (r_edge_cnt == w_last_edge);
    assign w_sample_pt = (r_edge_cnt == w_mid_p1);
    assign w_last_bit  = (r_bit_cnt == BW'(DATA_WIDTH - 1));

    // Third capture is the live line at mid+1; the vote is registered on that edge.
    assign w_vote = (r_cap0 & r_cap1) | (r_cap0 & rx_in) | (r_cap1 & rx_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!rx_in) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_sample_pt && w_vote) w_state_nxt = S_IDLE;
                else if (w_bit_end)        w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && w_last_bit) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc       <= '0;
            r_edge_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_par_en      <= 1'b0;
            r_par_typ     <= 1'b0;
            r_cap0        <= 1'b0;
            r_cap1        <= 1'b0;
            r_par_acc     <= 1'b0;
            r_deser_en    <= 1'b0;
            r_sampled_bit <= 1'b0;
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
        end else begin
            r_deser_en   <= 1'b0;
            r_data_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                r_edge_cnt <= '0;
                if (!rx_in) begin
                    r_presc   <= prescale;
                    r_par_en  <= par_en;
                    r_par_typ <= par_typ;
                    r_par_err <= 1'b0;
                    r_stp_err <= 1'b0;
                    r_par_acc <= 1'b0;
                end
            end else begin
                r_edge_cnt <= w_bit_end ? '0 : r_edge_cnt + PRESCALE_W'(1);
                if (r_edge_cnt == w_mid_m1) r_cap0 <= rx_in;
                if (r_edge_cnt == w_mid)    r_cap1 <= rx_in;
                if (w_sample_pt)            r_sampled_bit <= w_vote;
                case (r_state)
                    S_START: begin
                        if (w_sample_pt && w_vote) r_edge_cnt <= '0;
                        else if (w_bit_end)        r_bit_cnt  <= '0;
                    end
                    S_DATA: begin
                        if (w_sample_pt) begin
                            r_deser_en <= 1'b1;
                            r_par_acc  <= r_par_acc ^ w_vote;
                        end
                        if (w_bit_end && !w_last_bit) r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                    S_PARITY: begin
                        if (w_sample_pt) r_par_err <= w_vote ^ r_par_acc ^ r_par_typ;
                    end
                    S_STOP: begin
                        if (w_sample_pt) r_stp_err <= ~w_vote;
                        if (w_bit_end)   r_data_valid <= ~r_par_err & ~r_stp_err;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign deser_en    = r_deser_en;
    assign sampled_bit = r_sampled_bit;
    assign data_valid  = r_data_valid;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed and random frames driven bit-by-bit, with
// expected data bits, flags and good-frame counts derived from the frame contents.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       deser_en;
    logic       sampled_bit;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // Scoreboard state: expected data bits in arrival order, plus running totals.
    logic [0:0] exp_q[$];
    int         exp_dv_total = 0;
    logic       exp_pe = 1'b0;
    logic       exp_se = 1'b0;
    int         dv_cnt  = 0;
    int         des_cnt = 0;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .deser_en    (deser_en),
        .sampled_bit (sampled_bit),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every deser_en must match the next expected bit.
    always @(negedge clk) begin
        if (rst) begin
            if (deser_en) begin
                des_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_deser_en", 32'd1, 32'd0);
                end else begin
                    check("sampled_bit", {31'd0, sampled_bit}, {31'd0, exp_q.pop_front()});
                end
            end
            if (data_valid) begin
                dv_cnt++;
                check("dv_with_err", {30'd0, par_err, stp_err}, 32'd0);
            end
        end
    end

    // Reference model: what a frame with these contents must produce.
    task automatic model_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                               input logic pbit, input logic sbit);
        logic want_par;
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        want_par = (^d) ^ ptyp;
        exp_pe   = pen && (pbit != want_par);
        exp_se   = !sbit;
        if (!exp_pe && !exp_se) exp_dv_total++;
    endtask

    // Driver: one bit cell of p clocks, optionally inverting a single clock.
    task automatic drive_bit(input logic v, input int p, input int glitch_at);
        for (int i = 0; i < p; i++) begin
            rx_in = (i == glitch_at) ? ~v : v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int p, input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic pbit, input logic sbit,
                              input int g_bit, input logic scramble);
        prescale = 6'(p);
        par_en   = pen;
        par_typ  = ptyp;
        model_frame(d, pen, ptyp, pbit, sbit);
        drive_bit(1'b0, p, -1);
        check("busy_mid", {31'd0, busy}, 32'd1);
        check("flags_clear", {30'd0, par_err, stp_err}, 32'd0);
        if (scramble) begin
            prescale = (p == 16) ? 6'd8 : 6'd16;
            par_en   = ~pen;
            par_typ  = ~ptyp;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, (i == g_bit) ? (1 + p / 2) : -1);
        if (pen) drive_bit(pbit, p, -1);
        drive_bit(sbit, p, -1);
    endtask

    task automatic frame_end(input string tag, input int des_base, input int nbits);
        rx_in = 1'b1;
        for (int i = 0; i < 80 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_dv_count"}, dv_cnt, exp_dv_total);
        check({tag, "_par_err"}, {31'd0, par_err}, {31'd0, exp_pe});
        check({tag, "_stp_err"}, {31'd0, stp_err}, {31'd0, exp_se});
        check({tag, "_deser_count"}, des_cnt - des_base, nbits);
        check({tag, "_bits_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int des_base;
        int dv_base;
        int p;
        logic [7:0] d;
        logic pen, ptyp, pbit, sbit;

        rst      = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {26'd0, deser_en, sampled_bit, data_valid, par_err, stp_err, busy}, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        // Good frame with even parity
        des_base = des_cnt;
        send_frame(8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        frame_end("a5", des_base, 8);

        // Start glitch of two clocks
        des_base = des_cnt;
        dv_base  = dv_cnt;
        prescale = 6'd8;
        drive_bit(1'b0, 2, -1);
        rx_in = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_deser", des_cnt - des_base, 32'd0);
        check("glitch_dv", dv_cnt - dv_base, 32'd0);
        check("glitch_flags", {30'd0, par_err, stp_err}, 32'd0);

        // Bad stop bit, then a frame whose start must clear the flag
        des_base = des_cnt;
        send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        frame_end("stop_bad", des_base, 8);

        // Odd parity, wrong parity bit
        des_base = des_cnt;
        send_frame(16, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        frame_end("par_bad", des_base, 8);

        // Back-to-back frames, no idle gap
        des_base = des_cnt;
        send_frame(16, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        send_frame(16, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        frame_end("b2b", des_base, 16);

        // Single-clock glitch on data bit 3 is voted out
        des_base = des_cnt;
        send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        frame_end("noise", des_base, 8);

        // Random frames; config is scrambled after the start bit
        for (int n = 0; n < 6; n++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            d    = 8'($urandom);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            pbit = ($urandom_range(0, 2) == 0) ? 1'($urandom_range(0, 1)) : ((^d) ^ ptyp);
            sbit = ($urandom_range(0, 3) != 0);
            des_base = des_cnt;
            send_frame(p, d, pen, ptyp, pbit, sbit, -1, 1'b1);
            frame_end("rand", des_base, 8);
        end

        // Reset in the middle of DATA aborts the frame
        dv_base  = dv_cnt;
        prescale = 6'd8;
        par_en   = 1'b0;
        model_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 8, -1);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 8, -1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_outputs", {26'd0, deser_en, sampled_bit, data_valid, par_err, stp_err, busy}, 32'd0);
        exp_q.delete();
        exp_dv_total = dv_base;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        des_base = des_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid_idle", {31'd0, busy}, 32'd0);
        check("rst_mid_no_dv", dv_cnt - dv_base, 32'd0);
        check("rst_mid_no_deser", des_cnt - des_base, 32'd0);

        // Recovery frame after the abort
        des_base = des_cnt;
        send_frame(8, 8'h96, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        frame_end("recover", des_base, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
